// File: rtl/mem_access_ctrl.sv
// MEM-stage data-bus sequencer: turns one load/store into one bus transaction,
// stalls the pipeline until it completes, aligns/extends load data, reports faults.
//
// state | meaning
// IDLE  | no transaction; decode MEM-stage access, launch or fault
// REQ   | dbus_req high, waiting for ack or timeout
// DONE  | transaction finished; stall released, result/fault pulsed
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read_m,
    input  logic        mem_write_m,
    input  logic [1:0]  data_size_m,
    input  logic        load_unsigned_m,
    input  logic [31:0] addr_m,
    input  logic [31:0] wdata_m,
    output logic        stall_o,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic        dbus_err,
    input  logic [31:0] dbus_rdata,
    output logic [31:0] rdata_m,
    output logic        rdata_valid,
    output logic        mem_fault,
    output logic [1:0]  fault_cause
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       lat_size;
    logic [1:0]       lat_off;
    logic             lat_uns;

    logic        access, illegal, aligned, start, timeout;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] shifted;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_val;

    always_comb begin
        access  = mem_read_m ^ mem_write_m;
        illegal = mem_read_m & mem_write_m;
        case (data_size_m)
            2'b00: begin
                aligned = 1'b1;
                be_c    = 4'b0001 << addr_m[1:0];
                wdata_c = {4{wdata_m[7:0]}};
            end
            2'b01: begin
                aligned = ~addr_m[0];
                be_c    = addr_m[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{wdata_m[15:0]}};
            end
            default: begin
                aligned = (addr_m[1:0] == 2'b00);
                be_c    = 4'b1111;
                wdata_c = wdata_m;
            end
        endcase
        start   = (state == IDLE) && access && aligned;
        timeout = (cnt == TO_LAST);
    end

    // Lane selection uses the offset/size latched at launch, not the live inputs.
    always_comb begin
        shifted = dbus_rdata >> {lat_off, 3'b000};
        lane_b  = shifted[7:0];
        lane_h  = lat_off[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        case (lat_size)
            2'b00:   load_val = {{24{~lat_uns & lane_b[7]}}, lane_b};
            2'b01:   load_val = {{16{~lat_uns & lane_h[15]}}, lane_h};
            default: load_val = dbus_rdata;
        endcase
    end

    always_comb begin
        state_nxt = state;
        stall_o   = 1'b0;
        case (state)
            IDLE: begin
                stall_o = start;
                if (start) state_nxt = REQ;
            end
            REQ: begin
                stall_o = 1'b1;
                if (dbus_ack || timeout) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            lat_size    <= 2'b00;
            lat_off     <= 2'b00;
            lat_uns     <= 1'b0;
            dbus_req    <= 1'b0;
            dbus_we     <= 1'b0;
            dbus_addr   <= 32'h0;
            dbus_be     <= 4'h0;
            dbus_wdata  <= 32'h0;
            rdata_m     <= 32'h0;
            rdata_valid <= 1'b0;
            mem_fault   <= 1'b0;
            fault_cause <= 2'b00;
        end else begin
            state       <= state_nxt;
            rdata_valid <= 1'b0;
            mem_fault   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dbus_req   <= 1'b1;
                        dbus_we    <= mem_write_m;
                        dbus_addr  <= {addr_m[31:2], 2'b00};
                        dbus_be    <= be_c;
                        dbus_wdata <= wdata_c;
                        cnt        <= '0;
                        lat_size   <= data_size_m;
                        lat_off    <= addr_m[1:0];
                        lat_uns    <= load_unsigned_m;
                    end else if (illegal) begin
                        mem_fault   <= 1'b1;
                        fault_cause <= 2'b00;
                    end else if (access) begin
                        mem_fault   <= 1'b1;
                        fault_cause <= 2'b01;
                    end
                end
                REQ: begin
                    if (dbus_ack) begin
                        dbus_req <= 1'b0;
                        if (dbus_err) begin
                            mem_fault   <= 1'b1;
                            fault_cause <= 2'b10;
                            if (!dbus_we) rdata_m <= 32'h0;
                        end else if (!dbus_we) begin
                            rdata_m     <= load_val;
                            rdata_valid <= 1'b1;
                        end
                    end else if (timeout) begin
                        dbus_req    <= 1'b0;
                        mem_fault   <= 1'b1;
                        fault_cause <= 2'b11;
                        if (!dbus_we) rdata_m <= 32'h0;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a short timeout (4 cycles).
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read_m = 1'b0, mem_write_m = 1'b0, load_unsigned_m = 1'b0;
    logic [1:0]  data_size_m = 2'b00;
    logic [31:0] addr_m = '0, wdata_m = '0;
    logic        stall_o, dbus_req, dbus_we;
    logic [31:0] dbus_addr, dbus_wdata, rdata_m;
    logic [3:0]  dbus_be;
    logic        dbus_ack = 1'b0, dbus_err = 1'b0;
    logic [31:0] dbus_rdata = '0;
    logic        rdata_valid, mem_fault;
    logic [1:0]  fault_cause;

    int vecs = 0;
    int errs = 0;

    // Observations from the last run_access call
    int          stall_cnt, req_cnt, rv_cnt, flt_cnt;
    logic        obs_we;
    logic [3:0]  obs_be;
    logic [31:0] obs_addr, obs_wdata;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
        .data_size_m(data_size_m), .load_unsigned_m(load_unsigned_m),
        .addr_m(addr_m), .wdata_m(wdata_m), .stall_o(stall_o),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
        .dbus_ack(dbus_ack), .dbus_err(dbus_err), .dbus_rdata(dbus_rdata),
        .rdata_m(rdata_m), .rdata_valid(rdata_valid),
        .mem_fault(mem_fault), .fault_cause(fault_cause)
    );

    // Presents one MEM-stage instruction, acks on req cycle ack_at (-1 = never),
    // drops the instruction once the stall releases, then watches 3 idle cycles.
    task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                              input logic uns, input logic [31:0] a, input logic [31:0] wd,
                              input int ack_at, input logic err, input logic [31:0] rdat);
        int  req_idx = 0;
        int  tail = 0;
        bit  done = 0;
        stall_cnt = 0; req_cnt = 0; rv_cnt = 0; flt_cnt = 0;
        obs_we = 1'b0; obs_be = 4'h0; obs_addr = '0; obs_wdata = '0;
        @(posedge clk); #1;
        mem_read_m = rd; mem_write_m = wr; data_size_m = sz;
        load_unsigned_m = uns; addr_m = a; wdata_m = wd;
        for (int c = 0; c < 40 && tail < 3; c++) begin
            dbus_ack   = dbus_req && (req_idx == ack_at);
            dbus_err   = dbus_ack && err;
            dbus_rdata = dbus_ack ? rdat : 32'h0;
            @(negedge clk);
            if (stall_o) stall_cnt++;
            if (dbus_req) begin
                req_cnt++; req_idx++;
                obs_we = dbus_we; obs_be = dbus_be; obs_addr = dbus_addr; obs_wdata = dbus_wdata;
            end
            if (rdata_valid) rv_cnt++;
            if (mem_fault) flt_cnt++;
            @(posedge clk); #1;
            if (done) tail++;
            if (!stall_o && !done) begin
                done = 1;
                mem_read_m = 1'b0; mem_write_m = 1'b0;
            end
        end
        dbus_ack = 1'b0; dbus_err = 1'b0; dbus_rdata = '0;
        mem_read_m = 1'b0; mem_write_m = 1'b0;
        vecs++;
        if (!done) begin errs++; $display("FAIL run_done stall never released at %h", a); end
    endtask

    task automatic test_reset;
        vecs++; if (dbus_req !== 1'b0) begin errs++; $display("FAIL rst_req got %b want 0", dbus_req); end
        vecs++; if (stall_o !== 1'b0) begin errs++; $display("FAIL rst_stall got %b want 0", stall_o); end
        vecs++; if ({dbus_we, dbus_be, dbus_addr, dbus_wdata} !== '0) begin errs++; $display("FAIL rst_bus got %h want 0", {dbus_we, dbus_be, dbus_addr, dbus_wdata}); end
        vecs++; if ({rdata_m, rdata_valid, mem_fault, fault_cause} !== '0) begin errs++; $display("FAIL rst_out got %h want 0", {rdata_m, rdata_valid, mem_fault, fault_cause}); end
    endtask

    task automatic test_word_load;
        run_access(1, 0, 2'b10, 0, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF);
        vecs++; if (obs_be !== 4'b1111) begin errs++; $display("FAIL wl_be got %b want 1111", obs_be); end
        vecs++; if (obs_addr !== 32'h100 || obs_we !== 1'b0) begin errs++; $display("FAIL wl_addr got %h/%b want 100/0", obs_addr, obs_we); end
        vecs++; if (stall_cnt != 2) begin errs++; $display("FAIL wl_stall got %0d want 2", stall_cnt); end
        vecs++; if (req_cnt != 1) begin errs++; $display("FAIL wl_req got %0d want 1", req_cnt); end
        vecs++; if (rdata_m !== 32'hDEADBEEF) begin errs++; $display("FAIL wl_rdata got %h want deadbeef", rdata_m); end
        vecs++; if (rv_cnt != 1 || flt_cnt != 0) begin errs++; $display("FAIL wl_pulse got rv=%0d flt=%0d want 1/0", rv_cnt, flt_cnt); end
    endtask

    task automatic test_subword_load;
        run_access(1, 0, 2'b00, 0, 32'h103, 32'h0, 0, 0, 32'h80FF_0000);
        vecs++; if (obs_be !== 4'b1000) begin errs++; $display("FAIL sb_be got %b want 1000", obs_be); end
        vecs++; if (rdata_m !== 32'hFFFFFF80) begin errs++; $display("FAIL sb_rdata got %h want ffffff80", rdata_m); end
        run_access(1, 0, 2'b00, 1, 32'h103, 32'h0, 0, 0, 32'h80FF_0000);
        vecs++; if (rdata_m !== 32'h00000080) begin errs++; $display("FAIL ub_rdata got %h want 00000080", rdata_m); end
        run_access(1, 0, 2'b01, 0, 32'h102, 32'h0, 0, 0, 32'h80FF_0000);
        vecs++; if (obs_be !== 4'b1100 || rdata_m !== 32'hFFFF80FF) begin errs++; $display("FAIL sh_rdata got %b/%h want 1100/ffff80ff", obs_be, rdata_m); end
        run_access(1, 0, 2'b01, 1, 32'h100, 32'h0, 1, 0, 32'h1234_F00D);
        vecs++; if (obs_be !== 4'b0011 || rdata_m !== 32'h0000F00D) begin errs++; $display("FAIL uh_rdata got %b/%h want 0011/0000f00d", obs_be, rdata_m); end
        vecs++; if (stall_cnt != 3) begin errs++; $display("FAIL uh_stall got %0d want 3", stall_cnt); end
    endtask

    task automatic test_stores;
        run_access(0, 1, 2'b01, 0, 32'h202, 32'h1234ABCD, 3, 0, 32'h5555_5555);
        vecs++; if (obs_we !== 1'b1 || obs_be !== 4'b1100) begin errs++; $display("FAIL hs_we_be got %b/%b want 1/1100", obs_we, obs_be); end
        vecs++; if (obs_wdata !== 32'hABCDABCD || obs_addr !== 32'h200) begin errs++; $display("FAIL hs_data got %h/%h want abcdabcd/200", obs_wdata, obs_addr); end
        vecs++; if (stall_cnt != 5 || req_cnt != 4) begin errs++; $display("FAIL hs_stall got %0d/%0d want 5/4", stall_cnt, req_cnt); end
        vecs++; if (rv_cnt != 0 || rdata_m !== 32'h0000F00D) begin errs++; $display("FAIL hs_rdata got rv=%0d %h want 0/0000f00d", rv_cnt, rdata_m); end
        run_access(0, 1, 2'b00, 0, 32'h201, 32'h0000_00CD, 0, 0, 32'h0);
        vecs++; if (obs_be !== 4'b0010 || obs_wdata !== 32'hCDCDCDCD) begin errs++; $display("FAIL bs_data got %b/%h want 0010/cdcdcdcd", obs_be, obs_wdata); end
    endtask

    task automatic test_faults;
        run_access(1, 0, 2'b10, 0, 32'h101, 32'h0, 0, 0, 32'h0);
        vecs++; if (req_cnt != 0 || stall_cnt != 0) begin errs++; $display("FAIL mis_bus got req=%0d stall=%0d want 0/0", req_cnt, stall_cnt); end
        vecs++; if (flt_cnt != 1 || fault_cause !== 2'b01) begin errs++; $display("FAIL mis_fault got %0d/%b want 1/01", flt_cnt, fault_cause); end
        run_access(1, 1, 2'b10, 0, 32'h100, 32'h0, 0, 0, 32'h0);
        vecs++; if (req_cnt != 0 || flt_cnt != 1 || fault_cause !== 2'b00) begin errs++; $display("FAIL ill_fault got req=%0d %0d/%b want 0/1/00", req_cnt, flt_cnt, fault_cause); end
        run_access(1, 0, 2'b10, 0, 32'h104, 32'h0, 0, 0, 32'h1234_5678);
        vecs++; if (rdata_m !== 32'h12345678) begin errs++; $display("FAIL pre_err got %h want 12345678", rdata_m); end
        run_access(1, 0, 2'b10, 0, 32'h108, 32'h0, 1, 1, 32'hAAAA_AAAA);
        vecs++; if (flt_cnt != 1 || fault_cause !== 2'b10 || rv_cnt != 0) begin errs++; $display("FAIL err_fault got %0d/%b rv=%0d want 1/10/0", flt_cnt, fault_cause, rv_cnt); end
        vecs++; if (rdata_m !== 32'h0 || stall_cnt != 3) begin errs++; $display("FAIL err_rdata got %h stall=%0d want 0/3", rdata_m, stall_cnt); end
        run_access(1, 0, 2'b10, 0, 32'h104, 32'h0, 0, 0, 32'h1234_5678);
        run_access(1, 0, 2'b10, 0, 32'h300, 32'h0, -1, 0, 32'h0);
        vecs++; if (req_cnt != 4 || stall_cnt != 5) begin errs++; $display("FAIL to_len got req=%0d stall=%0d want 4/5", req_cnt, stall_cnt); end
        vecs++; if (flt_cnt != 1 || fault_cause !== 2'b11 || rdata_m !== 32'h0) begin errs++; $display("FAIL to_fault got %0d/%b %h want 1/11/0", flt_cnt, fault_cause, rdata_m); end
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        mem_read_m = 1'b1; data_size_m = 2'b10; addr_m = 32'h400;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vecs++; if (dbus_req !== 1'b1) begin errs++; $display("FAIL rm_inreq got %b want 1", dbus_req); end
        #2 rst_n = 1'b0;
        #1;
        vecs++; if (dbus_req !== 1'b0 || dbus_be !== 4'h0 || dbus_addr !== 32'h0) begin errs++; $display("FAIL rm_drop got %b/%b/%h want 0", dbus_req, dbus_be, dbus_addr); end
        vecs++; if (mem_fault !== 1'b0 || rdata_m !== 32'h0 || fault_cause !== 2'b00) begin errs++; $display("FAIL rm_out got %b/%h/%b want 0", mem_fault, rdata_m, fault_cause); end
        mem_read_m = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        run_access(1, 0, 2'b00, 1, 32'h402, 32'h0, 2, 0, 32'h00C3_0000);
        vecs++; if (rdata_m !== 32'h000000C3 || rv_cnt != 1 || flt_cnt != 0) begin errs++; $display("FAIL rm_after got %h rv=%0d flt=%0d want c3/1/0", rdata_m, rv_cnt, flt_cnt); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        @(negedge clk); rst_n = 1'b1;
        test_word_load;
        test_subword_load;
        test_stores;
        test_faults;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
